sseg_scan_decoder: RTL and testbench

Receive-side counterpart of the hex-to-seven-segment encoder: samples the multiplexed active-low anode and segment lines driving a 4-digit display and reconstructs the displayed hex digits, decimal points and per-digit validity. Sits in loopback/self-check paths of the FP adder board design, tapping the display driver outputs so a checker or UART reporter can read back what is shown. Filters scan transitions with a stability counter and publishes complete frames atomically.

---
 rtl/sseg_pkg.sv | 31 +++
 rtl/sseg_to_hex.sv | 36 +++
 rtl/sseg_scan_decoder.sv | 134 +++++++++++++
 tb/tb_sseg_scan_decoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan decoder: segment code table,
// blank pattern and the capture FSM state encoding.
package sseg_pkg;

  // Active-low segment patterns, a at bit 6 down to g at bit 0.
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [6:0] BLANK_CODE = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_t;

endpackage

// File: rtl/sseg_to_hex.sv
// Combinational reverse lookup of a seven-segment pattern to its hex nibble;
// anything outside the table (blank included) reads as 0 with err set.
import sseg_pkg::*;

module sseg_to_hex (
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    nibble = 4'h0;
    err    = 1'b0;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Samples the multiplexed anode/segment lines, debounces each digit dwell and
// publishes reconstructed 4-digit frames atomically with a frame_valid pulse.
import sseg_pkg::*;

module sseg_scan_decoder #(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_DIGITS-1:0]   an,
  input  logic [7:0]            sseg,
  output logic [4*N_DIGITS-1:0] hex,
  output logic [N_DIGITS-1:0]   dp,
  output logic [N_DIGITS-1:0]   err,
  output logic                  frame_valid
);

  localparam int         IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [7:0] CNT_HIT = 8'(STABLE_CYCLES - 1);

  logic [N_DIGITS-1:0] s_an, p_an;
  logic [7:0]          s_seg, p_seg;
  state_t              state, state_n;
  logic [7:0]          cnt, cnt_n;
  logic [N_DIGITS-1:0] seen;
  logic [3:0]          slot_hex [N_DIGITS];
  logic [N_DIGITS-1:0] slot_dp, slot_err;

  logic                same, an_ok, hit, cap, frame_done;
  logic [IW-1:0]       dig_idx;
  logic [N_DIGITS-1:0] cap_mask;
  logic [3:0]          dec_nib;
  logic                dec_err;

  sseg_to_hex u_dec (
    .seg    (s_seg[6:0]),
    .nibble (dec_nib),
    .err    (dec_err)
  );

  assign same       = ({s_an, s_seg} == {p_an, p_seg});
  assign an_ok      = ($countones(~s_an) == 1);
  // A capture needs STABLE_CYCLES consecutive identical samples in S.
  assign hit        = same && (cnt == CNT_HIT);
  assign frame_done = &seen;
  assign cap_mask   = cap ? ~s_an : '0;

  always_comb begin
    dig_idx = '0;
    for (int i = 0; i < N_DIGITS; i++)
      if (!s_an[i]) dig_idx = IW'(i);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_an  <= '1;
      p_an  <= '1;
      s_seg <= '1;
      p_seg <= '1;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      p_an  <= s_an;
      p_seg <= s_seg;
      s_an  <= an;
      s_seg <= sseg;
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (an_ok) begin
          state_n = SETTLE;
          cnt_n   = 8'd1;
        end else begin
          cnt_n   = '0;
        end
      end
      SETTLE, HELD: begin
        if (!same) begin
          state_n = an_ok ? SETTLE : IDLE;
          cnt_n   = an_ok ? 8'd1 : 8'd0;
        end else if (state == SETTLE) begin
          cnt_n   = cnt + 8'd1;
          if (hit) state_n = HELD;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    cap = (state == SETTLE) && hit;
  end

  // NOTE: working slots carry no reset; seen gates their use, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (cap) begin
      slot_hex[dig_idx] <= dec_nib;
      slot_dp[dig_idx]  <= s_seg[7];
      slot_err[dig_idx] <= dec_err;
    end
  end

  // Commit copies slots as they stood at completion; a same-edge capture seeds the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen        <= '0;
      hex         <= '0;
      dp          <= '0;
      err         <= '1;
      frame_valid <= 1'b0;
    end else begin
      seen        <= (frame_done ? '0 : seen) | cap_mask;
      frame_valid <= frame_done;
      if (frame_done) begin
        for (int i = 0; i < N_DIGITS; i++) hex[4*i +: 4] <= slot_hex[i];
        dp  <= slot_dp;
        err <= slot_err;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: scripted scans push expected frames to a
// scoreboard that a negedge monitor pops and checks on every frame_valid pulse.
import sseg_pkg::*;

module tb_sseg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic [15:0] hex;
  logic [3:0]  dp;
  logic [3:0]  err;
  logic        frame_valid;

  typedef struct {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  err;
  } frame_t;

  frame_t sb[$];
  int     total    = 0;
  int     bad      = 0;
  int     n_frames = 0;

  sseg_scan_decoder #(.N_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .sseg        (sseg),
    .hex         (hex),
    .dp          (dp),
    .err         (err),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // Called just after a rising edge; leaves the pattern on the lines for cyc edges.
  task automatic show(input int d, input logic [6:0] code, input logic dpv, input int cyc);
    an   = ~(4'b0001 << d);
    sseg = {dpv, code};
    repeat (cyc) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic blank(input int cyc);
    an   = 4'hF;
    sseg = 8'hFF;
    repeat (cyc) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check(tag, sb.size(), 0);
  endtask

  task automatic push(input logic [15:0] h, input logic [3:0] d, input logic [3:0] e);
    frame_t f;
    f.hex = h;
    f.dp  = d;
    f.err = e;
    sb.push_back(f);
  endtask

  always @(negedge clk) begin
    if (!reset && frame_valid) begin
      n_frames++;
      check("frame_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        frame_t f;
        f = sb.pop_front();
        check("frame_hex", hex, f.hex);
        check("frame_dp",  dp,  f.dp);
        check("frame_err", err, f.err);
      end
    end
  end

  initial begin
    int frames_before;
    reset = 1'b1;
    an    = 4'hF;
    sseg  = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hex", hex, 16'h0000);
    check("reset_dp",  dp,  4'h0);
    check("reset_err", err, 4'hF);
    check("reset_fv",  frame_valid, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Clean scan 3..0 showing 1,2,3,4 with dp high.
    push(16'h1234, 4'hF, 4'h0);
    show(3, seg_of(4'h1), 1'b1, 6);
    show(2, seg_of(4'h2), 1'b1, 6);
    show(1, seg_of(4'h3), 1'b1, 6);
    show(0, seg_of(4'h4), 1'b1, 6);
    blank(2);
    drain("scan1_drain");
    check("scan1_frames", n_frames, 1);
    check("scan1_hex", hex, 16'h1234);

    // Dwell one cycle too short: nothing is ever captured.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    frames_before = n_frames;
    for (int r = 0; r < 2; r++)
      for (int d = 3; d >= 0; d--) show(d, seg_of(4'(d + 5)), 1'b1, 3);
    blank(20);
    check("short_frames", n_frames, frames_before);
    check("short_hex", hex, 16'h0000);
    check("short_dp",  dp,  4'h0);
    check("short_err", err, 4'hF);

    // Blank digit 0 decodes as 0 with its err bit set.
    push(16'hCBA0, 4'h0, 4'b0001);
    show(0, 7'b1111111, 1'b0, 6);
    show(1, seg_of(4'hA), 1'b0, 6);
    show(2, seg_of(4'hB), 1'b0, 6);
    show(3, seg_of(4'hC), 1'b0, 6);
    blank(2);
    drain("blank_drain");

    // Two anodes low mid-scan must not write anything.
    frames_before = n_frames;
    push(16'h5678, 4'b0101, 4'h0);
    show(3, seg_of(4'h5), 1'b0, 6);
    show(2, seg_of(4'h6), 1'b1, 6);
    an   = 4'b1100;
    sseg = {1'b1, seg_of(4'h3)};
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check("dual_state", 32'(dut.state), 32'(IDLE));
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("dual_state_end", 32'(dut.state), 32'(IDLE));
    check("dual_no_frame", n_frames, frames_before);
    show(1, seg_of(4'h7), 1'b0, 6);
    show(0, seg_of(4'h8), 1'b1, 6);
    blank(2);
    drain("dual_drain");
    check("dual_frames", n_frames, frames_before + 1);

    // Digit 2 recaptured before completion: last value wins, one frame.
    frames_before = n_frames;
    push(16'h19EF, 4'h0, 4'h0);
    show(2, seg_of(4'h5), 1'b0, 6);
    show(3, seg_of(4'h1), 1'b0, 6);
    show(2, seg_of(4'h9), 1'b0, 6);
    show(1, seg_of(4'hE), 1'b0, 6);
    show(0, seg_of(4'hF), 1'b0, 6);
    blank(10);
    drain("recap_drain");
    check("recap_frames", n_frames, frames_before + 1);

    // Reset after three captures discards the partial frame immediately.
    show(3, seg_of(4'h7), 1'b0, 6);
    show(2, seg_of(4'h7), 1'b0, 6);
    show(1, seg_of(4'h7), 1'b0, 6);
    check("pre_reset_hex", hex, 16'h19EF);
    reset = 1'b1;
    #1;
    check("midrst_hex", hex, 16'h0000);
    check("midrst_err", err, 4'hF);
    @(posedge clk);
    #1;
    reset = 1'b0;
    frames_before = n_frames;
    show(0, seg_of(4'h0), 1'b0, 6);
    blank(20);
    check("midrst_partial", n_frames, frames_before);
    push(16'hDEF0, 4'b1000, 4'h0);
    show(3, seg_of(4'hD), 1'b1, 6);
    show(2, seg_of(4'hE), 1'b0, 6);
    show(1, seg_of(4'hF), 1'b0, 6);
    show(0, seg_of(4'h0), 1'b0, 6);
    blank(2);
    drain("midrst_drain");
    check("midrst_frames", n_frames, frames_before + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
